// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and defaults for the unified memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic {ARB_IDLE, ARB_ACC} arb_state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;
   localparam int MEM_WAIT_CYCLES = 3;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// arb_wait_counter: counts the cycles an access holds the memory and flags the final one
module arb_wait_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last
);
   localparam int CW = $clog2(WAIT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // clear takes priority so every grant starts the count from zero
   always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
   // count register
   always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
   assign last = cnt_q == CW'(WAIT_CYCLES - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one async memory between the fetch port and the load/store port
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
   parameter bit RR_EN       = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   arb_state_t  state_q, state_d;
   owner_t      owner_q, owner_d, served_q, served_d;
   logic        we_q, we_d, if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic        if_ok, dm_ok, grant, grant_dm, done, last;

   // a port whose ack is high this cycle is finishing and must not be re-granted
   assign if_ok    = if_req && !if_ack_q;
   assign dm_ok    = dm_req && !dm_ack_q;
   assign grant_dm = dm_ok && (!if_ok || !RR_EN || served_q == OWN_IF);
   assign grant    = state_q == ARB_IDLE && (if_ok || dm_ok);
   assign done     = state_q == ARB_ACC && last;

   arb_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (grant || done),
      .en   (state_q == ARB_ACC),
      .last (last)
   );

   // next state: latch the winner at grant, complete and return data on the last wait cycle
   always_comb begin
      state_d    = grant ? ARB_ACC : done ? ARB_IDLE : state_q;
      owner_d    = grant ? (grant_dm ? OWN_DM : OWN_IF) : owner_q;
      addr_d     = grant ? word_align(grant_dm ? dm_addr : if_addr) : addr_q;
      we_d       = grant ? grant_dm && dm_we : we_q;
      wdata_d    = grant ? (grant_dm ? dm_wdata : '0) : wdata_q;
      served_d   = done ? owner_q : served_q;
      if_ack_d   = done && owner_q == OWN_IF;
      dm_ack_d   = done && owner_q == OWN_DM;
      if_rdata_d = if_ack_d ? mem_rdata : if_rdata_q;
      dm_rdata_d = dm_ack_d && !we_q ? mem_rdata : dm_rdata_q;
   end

   // arbiter FSM and its registered outputs; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         owner_q    <= OWN_IF;
         served_q   <= OWN_DM;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         served_q   <= served_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign mem_we    = done && owner_q == OWN_DM && we_q && !reset;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = state_q == ARB_ACC;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of three arbiter configurations against hand-derived timing
module tb_mem_port_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic [2:0] if_req = '0, dm_req = '0, dm_we = '0, pre_we = '0;
   logic [2:0] if_ack, dm_ack, mem_we, busy;
   logic [2:0][31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic [2:0][31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [2:0][7:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   int n_tests = 0, n_fail = 0, n;

   always #5 clk = ~clk;

   // instance 0: W=3 fixed priority, 1: W=3 round-robin, 2: W=1 fixed priority
   for (genvar g = 0; g < 3; g++) begin : gi
      logic [31:0] mem [0:255];
      int we_cnt = 0;
      mem_port_arbiter #(.WAIT_CYCLES(g == 2 ? 1 : 3), .RR_EN(g == 1)) u_dut (
         .clk(clk), .reset(reset),
         .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
         .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
         .dm_rdata(dm_rdata[g]), .dm_ack(dm_ack[g]),
         .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g]), .busy(busy[g])
      );
      assign mem_rdata[g] = mem[mem_addr[g][9:2]];
      always @(posedge clk) begin
         if (mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
         else if (pre_we[g]) mem[pre_addr[g]] <= pre_data;
      end
      always @(negedge clk) if (mem_we[g]) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int i, input logic [7:0] a, input logic [31:0] d);
      pre_we[i] = 1'b1;
      pre_addr[i] = a;
      pre_data = d;
      wait_edge();
      pre_we[i] = 1'b0;
   endtask

   task automatic wait_any(input int i, output int cnt);
      cnt = 0;
      do begin
         wait_edge();
         cnt++;
      end while (!(if_ack[i] || dm_ack[i]) && cnt < 20);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      wait_edge();
      wait_edge();
      check("rst_ctl", {28'd0, if_ack[0], dm_ack[0], busy[0], mem_we[0]}, 0);
      check("rst_addr", mem_addr[0], 0);
      check("rst_wdata", mem_wdata[0], 0);
      check("rst_rdata", if_rdata[0] | dm_rdata[0], 0);
      reset = 1'b0;
      preload(0, 8'd4, 32'h2402000A);
      preload(0, 8'h10, 32'h11112222);
      preload(2, 8'd4, 32'hCAFEF00D);
      // fetch only, with req held through the ack cycle
      if_addr[0] = 32'h10;
      if_req[0] = 1'b1;
      wait_edge();
      check("f_busy", busy[0], 1);
      check("f_addr", mem_addr[0], 32'h10);
      wait_edge();
      wait_edge();
      check("f_noack", if_ack[0], 0);
      wait_edge();
      check("f_ack", if_ack[0], 1);
      check("f_rdata", if_rdata[0], 32'h2402000A);
      wait_edge();
      check("f_hold", {30'd0, if_ack[0], busy[0]}, 0);
      if_req[0] = 1'b0;
      check("f_nowe", gi[0].we_cnt, 0);
      wait_edge();
      // store to 0x83, with addr/wdata scrambled mid-access
      dm_we[0] = 1'b1;
      dm_addr[0] = 32'h83;
      dm_wdata[0] = 32'hDEADBEEF;
      dm_req[0] = 1'b1;
      wait_edge();
      check("s_addr", mem_addr[0], 32'h80);
      check("s_wdata", mem_wdata[0], 32'hDEADBEEF);
      check("s_we0", mem_we[0], 0);
      wait_edge();
      check("s_we1", mem_we[0], 0);
      dm_addr[0] = 32'h44;
      dm_wdata[0] = 32'h12345678;
      wait_edge();
      check("s_we2", mem_we[0], 1);
      check("s_addr2", mem_addr[0], 32'h80);
      wait_edge();
      check("s_ack", dm_ack[0], 1);
      check("s_we3", mem_we[0], 0);
      check("s_rdata", dm_rdata[0], 0);
      check("s_mem", gi[0].mem[32], 32'hDEADBEEF);
      check("s_wecnt", gi[0].we_cnt, 1);
      dm_req[0] = 1'b0;
      wait_edge();
      // load back
      dm_we[0] = 1'b0;
      dm_addr[0] = 32'h80;
      dm_req[0] = 1'b1;
      wait_any(0, n);
      check("l_lat", n, 4);
      check("l_rdata", dm_rdata[0], 32'hDEADBEEF);
      dm_req[0] = 1'b0;
      wait_edge();
      // tie with fixed priority: DM first, then IF granted in the DM ack cycle
      if_req[0] = 1'b1;
      dm_req[0] = 1'b1;
      wait_any(0, n);
      check("t_lat", n, 4);
      check("t_who", {30'd0, if_ack[0], dm_ack[0]}, 32'b01);
      dm_req[0] = 1'b0;
      wait_any(0, n);
      check("t_lat2", n, 4);
      check("t_who2", {30'd0, if_ack[0], dm_ack[0]}, 32'b10);
      if_req[0] = 1'b0;
      wait_edge();
      // reset while a store to 0x40 is in flight
      dm_we[0] = 1'b1;
      dm_addr[0] = 32'h40;
      dm_wdata[0] = 32'hBAD0BAD0;
      dm_req[0] = 1'b1;
      wait_edge();
      wait_edge();
      reset = 1'b1;
      wait_edge();
      check("r_ctl", {28'd0, if_ack[0], dm_ack[0], busy[0], mem_we[0]}, 0);
      reset = 1'b0;
      dm_req[0] = 1'b0;
      wait_edge();
      check("r_ctl2", {28'd0, if_ack[0], dm_ack[0], busy[0], mem_we[0]}, 0);
      check("r_out", mem_addr[0] | mem_wdata[0] | if_rdata[0] | dm_rdata[0], 0);
      check("r_mem", gi[0].mem[16], 32'h11112222);
      check("r_wecnt", gi[0].we_cnt, 1);
      dm_we[0] = 1'b0;
      dm_req[0] = 1'b1;
      wait_any(0, n);
      check("r_lat", n, 4);
      check("r_rdata", dm_rdata[0], 32'h11112222);
      dm_req[0] = 1'b0;
      // round-robin ties alternate starting with fetch
      if_addr[1] = 32'h10;
      dm_addr[1] = 32'h80;
      for (int k = 0; k < 4; k++) begin
         if_req[1] = 1'b1;
         dm_req[1] = 1'b1;
         wait_any(1, n);
         check($sformatf("rr%0d_lat", k), n, 4);
         check($sformatf("rr%0d_who", k), {30'd0, if_ack[1], dm_ack[1]}, k % 2 == 0 ? 32'b10 : 32'b01);
         if_req[1] = 1'b0;
         dm_req[1] = 1'b0;
         wait_edge();
      end
      // WAIT_CYCLES=1 with both ports requesting continuously
      if_addr[2] = 32'h10;
      dm_we[2] = 1'b1;
      dm_addr[2] = 32'h20;
      dm_wdata[2] = 32'h55AA55AA;
      if_req[2] = 1'b1;
      dm_req[2] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wait_edge();
         check($sformatf("w1_c%0d", k), {29'd0, if_ack[2], dm_ack[2], mem_we[2]},
               {29'd0, k == 3 || k == 7, k == 1 || k == 5, k == 0 || k == 4});
      end
      if_req[2] = 1'b0;
      dm_req[2] = 1'b0;
      wait_edge();
      check("w1_rdata", if_rdata[2], 32'hCAFEF00D);
      check("w1_mem", gi[2].mem[8], 32'h55AA55AA);
      check("w1_wecnt", gi[2].we_cnt, 2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
